// File: rtl/uart_pkg.sv
// Definitions shared by the UART receiver and transmitter: frame state encoding,
// default bit timing and data width.
package uart_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 104;
    localparam int DATA_BITS            = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } uart_state_e;

    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_if.sv
// Consumer-side byte handshake of the UART receiver: buffered byte, status flags, read strobe.
interface uart_if;
    import uart_pkg::*;

    logic                 rd;
    logic [DATA_BITS-1:0] data_out;
    logic                 rxne;
    logic                 frame_err;
    logic                 overrun;

    modport master (input rd, output data_out, output rxne, output frame_err, output overrun);
    modport slave  (output rd, input data_out, input rxne, input frame_err, input overrun);

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous rx pad plus falling-edge detect on the
// synchronised line. All flops reset to the idle (high) level.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic rxs,
    output logic fall
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= rx;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rxs  = sync_q;
    assign fall = prev_q & ~sync_q;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with mid-bit sampling and a one-byte receive buffer.
// Define UART_RX_PARITY_EN for 8E1 frames (even parity bit checked before stop).
//
//  state     | meaning
//  ----------+-------------------------------------------------------------
//  ST_IDLE   | line idle, waiting for a falling edge
//  ST_START  | half-bit wait, then confirm start bit is still low
//  ST_DATA   | sample 8 data bits at bit centres, LSB first
//  ST_PARITY | sample even-parity bit (parity build only)
//  ST_STOP   | sample stop bit; deliver byte or flag frame error
//  ST_BREAK  | line held low after a bad stop bit; wait for idle level
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int CNT_W        = 16
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   rx,
    uart_if.master bus
);

    localparam int                IDX_W    = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0]  T_HALF   = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]  T_FULL   = CNT_W'(CLKS_PER_BIT - 1);

    logic                 rxs;
    logic                 fall;

    uart_state_e          state_q, state_d;
    logic [CNT_W-1:0]     timer_q, timer_d, timer_dec;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 tick;
    logic                 deliver;
    logic                 ferr;

    logic [DATA_BITS-1:0] data_q;
    logic                 rxne_q;
    logic                 ferr_q;
    logic                 ovr_q;

`ifdef UART_RX_PARITY_EN
    logic                 perr_q, perr_d;
`endif

    uart_rx_sync u_sync (
        .clk  (clk),
        .rst  (rst),
        .rx   (rx),
        .rxs  (rxs),
        .fall (fall)
    );

    assign tick      = (timer_q == '0);
    assign timer_dec = timer_q - CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            bit_idx_q <= '0;
            shreg_q   <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) perr_q <= 1'b0;
        else     perr_q <= perr_d;
    end
`endif

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        deliver   = 1'b0;
        ferr      = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_d    = perr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (fall) begin
                    state_d = ST_START;
                    timer_d = T_HALF;
                end
            end
            ST_START: begin
                if (!tick) begin
                    timer_d = timer_dec;
                end else if (rxs) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d   = ST_DATA;
                    bit_idx_d = '0;
                    timer_d   = T_FULL;
                end
            end
            ST_DATA: begin
                if (!tick) begin
                    timer_d = timer_dec;
                end else begin
                    shreg_d   = {rxs, shreg_q[DATA_BITS-1:1]};
                    bit_idx_d = bit_idx_q + IDX_W'(1);
                    timer_d   = T_FULL;
                    if (bit_idx_q == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (!tick) begin
                    timer_d = timer_dec;
                end else begin
                    perr_d  = rxs ^ even_parity(shreg_q);
                    timer_d = T_FULL;
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (!tick) begin
                    timer_d = timer_dec;
                end else begin
                    // A bad parity with a good stop bit resyncs at once; a low stop bit means break.
`ifdef UART_RX_PARITY_EN
                    if (rxs && !perr_q) deliver = 1'b1;
`else
                    if (rxs) deliver = 1'b1;
`endif
                    else ferr = 1'b1;
                    state_d = rxs ? ST_IDLE : ST_BREAK;
                end
            end
            ST_BREAK: begin
                if (rxs) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Receive buffer: the line is never stalled, so a full buffer drops the new byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            rxne_q <= 1'b0;
            ferr_q <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            ferr_q <= ferr;
            if (deliver) begin
                if (!rxne_q || bus.rd) data_q <= shreg_q;
                if (rxne_q && !bus.rd) ovr_q <= 1'b1;
                rxne_q <= 1'b1;
            end else if (bus.rd && rxne_q) begin
                rxne_q <= 1'b0;
                ovr_q  <= 1'b0;
            end
        end
    end

    assign bus.data_out  = data_q;
    assign bus.rxne      = rxne_q;
    assign bus.frame_err = ferr_q;
    assign bus.overrun   = ovr_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: directed frames with an event-scheduled buffer model checked every cycle.
module tb_uart_receiver;
    import uart_pkg::*;

    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int LAT = 2 + CPB / 2 + (FRAME_BITS - 1) * CPB + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx  = 1'b1;

    uart_if bus();

    uart_receiver #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .rx  (rx),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         at;
        bit         good;
        logic [7:0] d;
    } ev_t;

    ev_t        evq[$];
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_err = 0;
    int         last_start = 0;
    int         rise_cyc = -1;
    int         ferr_cnt = 0;
    logic       prev_rxne = 1'b0;
    logic [7:0] m_data = 8'h00;
    logic       m_rxne = 1'b0;
    logic       m_ferr = 1'b0;
    logic       m_ovr  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Model: a frame's outcome is known when it starts; it lands LAT cycles later.
    task automatic model_step();
        bit         dlv;
        logic [7:0] nb;
        cyc++;
        dlv = 1'b0;
        nb  = 8'h00;
        m_ferr = 1'b0;
        if (rst) begin
            m_data = 8'h00;
            m_rxne = 1'b0;
            m_ovr  = 1'b0;
            evq.delete();
        end else begin
            if (evq.size() > 0 && evq[0].at == cyc) begin
                if (evq[0].good) begin
                    dlv = 1'b1;
                    nb  = evq[0].d;
                end else begin
                    m_ferr = 1'b1;
                end
                void'(evq.pop_front());
            end
            case ({dlv, m_rxne, bus.rd})
                3'b100, 3'b101: begin m_data = nb; m_rxne = 1'b1; end
                3'b110:         m_ovr = 1'b1;
                3'b111:         m_data = nb;
                3'b011:         begin m_rxne = 1'b0; m_ovr = 1'b0; end
                default:        ;
            endcase
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (cyc > 0) begin
            chk("rxne", {31'd0, bus.rxne}, {31'd0, m_rxne});
            chk("data_out", {24'd0, bus.data_out}, {24'd0, m_data});
            chk("frame_err", {31'd0, bus.frame_err}, {31'd0, m_ferr});
            chk("overrun", {31'd0, bus.overrun}, {31'd0, m_ovr});
            if (bus.rxne === 1'b1 && prev_rxne !== 1'b1) rise_cyc = cyc;
            prev_rxne = bus.rxne;
            if (bus.frame_err === 1'b1) ferr_cnt++;
        end
    end

    task automatic send_frame(input logic [7:0] b, input logic stop, input int hold_low,
                              input logic pflip);
        ev_t e;
        last_start = cyc;
        e.at   = cyc + LAT;
        e.d    = b;
`ifdef UART_RX_PARITY_EN
        e.good = stop && !pflip;
`else
        e.good = stop && (pflip || !pflip);
`endif
        evq.push_back(e);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^b) ^ pflip;
        tick(CPB);
`endif
        rx = stop;
        tick(CPB);
        if (!stop) begin
            tick(hold_low);
            rx = 1'b1;
        end
    endtask

    task automatic send_partial(input logic [7:0] b, input int nbits);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < nbits; i++) begin
            rx = b[i];
            tick(CPB);
        end
    endtask

    task automatic pop_byte();
        bus.rd = 1'b1;
        tick(1);
        bus.rd = 1'b0;
        tick(1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.rd = 1'b0;
        rst    = 1'b1;
        rx     = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(5);
        chk("reset_rxne", {31'd0, bus.rxne}, 32'd0);
        chk("reset_data", {24'd0, bus.data_out}, 32'd0);
        chk("reset_ferr", {31'd0, bus.frame_err}, 32'd0);
        chk("reset_ovr", {31'd0, bus.overrun}, 32'd0);

        // 1: single clean frame, latency from falling edge to rxne
        send_frame(8'h48, 1'b1, 0, 1'b0);
        tick(4);
        chk("t1_latency", rise_cyc - last_start, LAT);
        chk("t1_data", {24'd0, bus.data_out}, 32'h48);
        chk("t1_model_data", {24'd0, m_data}, 32'h48);
        chk("t1_rxne", {31'd0, bus.rxne}, 32'd1);
        pop_byte();
        chk("t1_pop", {31'd0, bus.rxne}, 32'd0);

        // 2: short low glitch is rejected at the start-bit centre
        ferr_cnt = 0;
        rx = 1'b0;
        tick(5);
        rx = 1'b1;
        tick(20);
        chk("t2_rxne", {31'd0, bus.rxne}, 32'd0);
        chk("t2_ferr_cnt", ferr_cnt, 32'd0);

        // 3: bad stop bit followed by held-low line, then a clean frame
        send_frame(8'h55, 1'b0, 40, 1'b0);
        tick(10);
        chk("t3_ferr_cnt", ferr_cnt, 32'd1);
        chk("t3_rxne", {31'd0, bus.rxne}, 32'd0);
        send_frame(8'hA5, 1'b1, 0, 1'b0);
        tick(4);
        chk("t3_data", {24'd0, bus.data_out}, 32'hA5);
        pop_byte();

        // 4: second byte arrives with buffer full and no read
        send_frame(8'h11, 1'b1, 0, 1'b0);
        tick(4);
        send_frame(8'h22, 1'b1, 0, 1'b0);
        tick(4);
        chk("t4_data", {24'd0, bus.data_out}, 32'h11);
        chk("t4_ovr", {31'd0, bus.overrun}, 32'd1);
        chk("t4_model_ovr", {31'd0, m_ovr}, 32'd1);
        pop_byte();
        chk("t4_pop_rxne", {31'd0, bus.rxne}, 32'd0);
        chk("t4_pop_ovr", {31'd0, bus.overrun}, 32'd0);

        // 5: read strobe coincides with the delivery of the second byte
        send_frame(8'h11, 1'b1, 0, 1'b0);
        tick(4);
        fork
            send_frame(8'h22, 1'b1, 0, 1'b0);
            begin
                tick(LAT - 1);
                bus.rd = 1'b1;
                tick(1);
                bus.rd = 1'b0;
            end
        join
        tick(4);
        chk("t5_data", {24'd0, bus.data_out}, 32'h22);
        chk("t5_rxne", {31'd0, bus.rxne}, 32'd1);
        chk("t5_ovr", {31'd0, bus.overrun}, 32'd0);
        pop_byte();

        // 6: reset in the middle of a frame, then a clean frame
        send_frame(8'h5A, 1'b1, 0, 1'b0);
        tick(4);
        send_partial(8'h7E, 4);
        rx  = 1'b1;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        chk("t6_rst_rxne", {31'd0, bus.rxne}, 32'd0);
        chk("t6_rst_data", {24'd0, bus.data_out}, 32'd0);
        chk("t6_rst_ferr", {31'd0, bus.frame_err}, 32'd0);
        chk("t6_rst_ovr", {31'd0, bus.overrun}, 32'd0);
        tick(10);
        send_frame(8'h3C, 1'b1, 0, 1'b0);
        tick(4);
        chk("t6_data", {24'd0, bus.data_out}, 32'h3C);
        pop_byte();
`ifdef UART_RX_PARITY_EN
        ferr_cnt = 0;
        send_frame(8'h3C, 1'b1, 0, 1'b1);
        tick(10);
        chk("t6_par_ferr_cnt", ferr_cnt, 32'd1);
        chk("t6_par_rxne", {31'd0, bus.rxne}, 32'd0);
`endif
        tick(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
